// File: rtl/peripheral_wb_pkg.sv
// rtl/peripheral_wb_pkg.sv - shared types and constants for the Wishbone UART transmitter
package peripheral_wb_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam int LCR_WLEN_LSB = 0;
    localparam int LCR_WLEN_MSB = 1;
    localparam int LCR_STOP     = 2;
    localparam int LCR_PEN      = 3;
    localparam int LCR_EPS      = 4;
    localparam int LCR_STICK    = 5;
    localparam int LCR_BREAK    = 6;

    localparam logic [4:0] STOP_TICKS_1   = 5'd15;
    localparam logic [4:0] STOP_TICKS_1P5 = 5'd23;
    localparam logic [4:0] STOP_TICKS_2   = 5'd31;

endpackage

// File: rtl/peripheral_uart_transmitter_wb.sv
// rtl/peripheral_uart_transmitter_wb.sv - 16550-style UART serialiser fed from the parent's TX FIFO
module peripheral_uart_transmitter_wb
    import peripheral_wb_pkg::*;
#(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    input  logic                      tx_reset,
    input  logic [FIFO_WIDTH-1:0]     tf_data,
    input  logic [FIFO_COUNTER_W-1:0] tf_count,
    output logic                      tf_pop,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic                      tx_busy
);

    tx_state_e  state_q, state_d;
    logic [4:0] tcnt_q, tcnt_d;
    logic [2:0] bits_left_q, bits_left_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] wlen_q, wlen_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic [4:0] stop_ticks_q, stop_ticks_d;
    logic       stx_q, stx_d;
    logic       pop_c;
    logic       line_c;

    logic [1:0] lcr_wlen;
    logic [7:0] head_masked;
    logic       head_parity;
    logic [4:0] head_stop;
    logic       unused_lcr7;

    assign unused_lcr7 = lcr[7];
    assign lcr_wlen    = lcr[LCR_WLEN_MSB:LCR_WLEN_LSB];
    assign head_masked = tf_data[7:0] & (8'hFF >> (2'd3 - lcr_wlen));

    // Frame configuration is captured from lcr at pop time so mid-frame writes cannot tear a frame.
    always_comb begin
        head_parity = 1'b0;
        if (lcr[LCR_STICK]) begin
            head_parity = ~lcr[LCR_EPS];
        end else if (lcr[LCR_EPS]) begin
            head_parity = ^head_masked;
        end else begin
            head_parity = ~^head_masked;
        end
        head_stop = STOP_TICKS_2;
        if (!lcr[LCR_STOP]) begin
            head_stop = STOP_TICKS_1;
        end else if (lcr_wlen == 2'd0) begin
            head_stop = STOP_TICKS_1P5;
        end
    end

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bits_left_d  = bits_left_q;
        shift_d      = shift_q;
        wlen_d       = wlen_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop_ticks_d = stop_ticks_q;
        pop_c        = 1'b0;
        if (tx_reset) begin
            state_d     = TX_IDLE;
            tcnt_d      = 5'd0;
            bits_left_d = 3'd0;
            shift_d     = 8'd0;
        end else if (enable) begin
            case (state_q)
                TX_IDLE: begin
                    if (tf_count != '0) begin
                        pop_c        = 1'b1;
                        shift_d      = head_masked;
                        wlen_d       = lcr_wlen;
                        par_en_d     = lcr[LCR_PEN];
                        par_bit_d    = head_parity;
                        stop_ticks_d = head_stop;
                        tcnt_d       = 5'd15;
                        state_d      = TX_START;
                    end
                end
                TX_START: begin
                    if (tcnt_q == 5'd0) begin
                        state_d     = TX_DATA;
                        tcnt_d      = 5'd15;
                        bits_left_d = {1'b0, wlen_q} + 3'd4;
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
                TX_DATA: begin
                    if (tcnt_q == 5'd0) begin
                        shift_d     = {1'b0, shift_q[7:1]};
                        bits_left_d = bits_left_q - 3'd1;
                        tcnt_d      = 5'd15;
                        if (bits_left_q == 3'd0) begin
                            if (par_en_q) begin
                                state_d = TX_PARITY;
                            end else begin
                                state_d = TX_STOP;
                                tcnt_d  = stop_ticks_q;
                            end
                        end
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
                TX_PARITY: begin
                    if (tcnt_q == 5'd0) begin
                        state_d = TX_STOP;
                        tcnt_d  = stop_ticks_q;
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
                TX_STOP: begin
                    if (tcnt_q == 5'd0) begin
                        state_d = TX_IDLE;
                        tcnt_d  = 5'd0;
                    end else begin
                        tcnt_d = tcnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                    tcnt_d  = 5'd0;
                end
            endcase
        end
    end

    // Line level follows the next state every clk so break takes hold without waiting for a tick.
    always_comb begin
        line_c = 1'b1;
        case (state_d)
            TX_START:  line_c = 1'b0;
            TX_DATA:   line_c = shift_d[0];
            TX_PARITY: line_c = par_bit_d;
            default:   line_c = 1'b1;
        endcase
        stx_d = tx_reset | (line_c & ~lcr[LCR_BREAK]);
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= TX_IDLE;
            tcnt_q       <= 5'd0;
            bits_left_q  <= 3'd0;
            shift_q      <= 8'd0;
            wlen_q       <= 2'd0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop_ticks_q <= 5'd0;
            stx_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bits_left_q  <= bits_left_d;
            shift_q      <= shift_d;
            wlen_q       <= wlen_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop_ticks_q <= stop_ticks_d;
            stx_q        <= stx_d;
        end
    end

    assign tf_pop    = pop_c & ~wb_rst_i;
    assign stx_pad_o = stx_q;
    assign tstate    = state_q;
    assign tx_busy   = (state_q != TX_IDLE);

endmodule

// File: tb/tb_peripheral_uart_transmitter_wb.sv
// tb/tb_peripheral_uart_transmitter_wb.sv - scoreboard bench for the UART transmitter
module tb_peripheral_uart_transmitter_wb;
    import peripheral_wb_pkg::*;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       enable = 1'b0;
    logic       tx_reset = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic [7:0] tf_data = 8'h00;
    logic [4:0] tf_count = 5'd0;
    logic       tf_pop;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic       tx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] lcr;
    } frame_t;

    int         total = 0;
    int         bad = 0;
    frame_t     exp_q[$];
    logic [7:0] fifo[$];
    int         pop_ticks[$];
    frame_t     cur;
    bit         cap[$];
    bit         capturing = 1'b0;
    bit         drop_frame = 1'b0;
    bit         en_prev = 1'b0;
    bit         pop_prev = 1'b0;
    int         tick_no = 0;

    peripheral_uart_transmitter_wb #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .lcr(lcr), .tx_reset(tx_reset),
        .tf_data(tf_data), .tf_count(tf_count), .tf_pop(tf_pop), .stx_pad_o(stx_pad_o),
        .tstate(tstate), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            enable = (c == 0);
            c = (c + 1) % 4;
        end
    end

    // Reference model: line level per baud tick derived from the frame format rules.
    function automatic int nbits(input logic [7:0] l);
        return int'(l[1:0]) + 5;
    endfunction

    function automatic int stop_len(input logic [7:0] l);
        if (!l[2]) return 16;
        if (l[1:0] == 2'd0) return 24;
        return 32;
    endfunction

    function automatic bit par_value(input frame_t f);
        int ones;
        ones = 0;
        for (int i = 0; i < nbits(f.lcr); i++) ones += int'(f.data[i]);
        if (f.lcr[5]) return !f.lcr[4];
        if (f.lcr[4]) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic int frame_len(input frame_t f);
        return 16 * (1 + nbits(f.lcr) + int'(f.lcr[3])) + stop_len(f.lcr) + 1;
    endfunction

    function automatic bit level_at(input frame_t f, input int t);
        int nb;
        int b;
        nb = nbits(f.lcr);
        b = t / 16;
        if (b == 0) return 1'b0;
        if (b <= nb) return f.data[b-1];
        if (f.lcr[3] && b == nb + 1) return par_value(f);
        return 1'b1;
    endfunction

    function automatic void fifo_drive();
        tf_count = 5'(fifo.size());
        tf_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] d);
        frame_t f;
        f.data = d;
        f.lcr  = lcr;
        fifo.push_back(d);
        exp_q.push_back(f);
        fifo_drive();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", name, got, need);
        end
    endtask

    task automatic finish_frame();
        int n;
        int first;
        n = frame_len(cur);
        first = -1;
        if (drop_frame) begin
            drop_frame = 1'b0;
            return;
        end
        total++;
        for (int i = 0; i < cap.size() && i < n; i++) begin
            if (first < 0 && cap[i] != level_at(cur, i)) first = i;
        end
        if (cap.size() != n || first >= 0) begin
            bad++;
            $display("FAIL frame data=%02h lcr=%02h: got %0d ticks first_bad_tick=%0d, need %0d ticks",
                     cur.data, cur.lcr, cap.size(), first, n);
        end
    endtask

    always @(negedge clk) begin
        if (wb_rst_i) begin
            en_prev  = 1'b0;
            pop_prev = 1'b0;
        end else begin
            if (en_prev) begin
                tick_no++;
                if (capturing) begin
                    cap.push_back(stx_pad_o);
                    if (!tx_busy) begin
                        capturing = 1'b0;
                        finish_frame();
                    end
                end
                if (pop_prev) begin
                    pop_ticks.push_back(tick_no);
                    if (fifo.size() != 0) void'(fifo.pop_front());
                    fifo_drive();
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop: got pop at tick %0d, need none", tick_no);
                    end else begin
                        cur = exp_q.pop_front();
                        cap.delete();
                        cap.push_back(stx_pad_o);
                        capturing = 1'b1;
                    end
                end
            end
            if (tf_pop) check("pop_only_on_enable", enable, 1);
            en_prev  = enable;
            pop_prev = tf_pop;
        end
    end

    task automatic wait_state(input logic [2:0] st);
        int n;
        n = 0;
        while (tstate !== st && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tstate !== st) begin
            total++;
            bad++;
            $display("FAIL wait_state: got state %0d, need %0d", tstate, st);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0 || capturing) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || fifo.size() != 0 || capturing) begin
            total++;
            bad++;
            $display("FAIL wait_done: got %0d frames outstanding, need 0", exp_q.size() + int'(capturing));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dir_lcr[6];
        logic [7:0] dir_dat[6];
        dir_lcr = '{8'h03, 8'h1A, 8'h0A, 8'h3A, 8'h04, 8'h07};
        dir_dat = '{8'hA5, 8'h41, 8'h41, 8'h41, 8'h15, 8'h3C};

        // Reset: byte already queued, pops must stay off while held in reset.
        repeat (2) @(posedge clk);
        #1;
        lcr = 8'h03;
        push(8'hA5);
        repeat (8) begin
            @(negedge clk);
            check("reset_tf_pop", tf_pop, 0);
        end
        check("reset_stx", stx_pad_o, 1);
        check("reset_tstate", tstate, 0);
        check("reset_busy", tx_busy, 0);
        pop_ticks.delete();
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        wait_done();
        check("8n1_pop_count", pop_ticks.size(), 1);

        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            lcr = dir_lcr[i];
            push(dir_dat[i]);
            wait_done();
        end

        // Empty FIFO stays idle.
        pop_ticks.delete();
        repeat (80) @(negedge clk);
        check("empty_no_pop", pop_ticks.size(), 0);
        check("empty_idle", tx_busy, 0);

        // Three queued bytes: pops one frame period apart.
        @(posedge clk);
        #1;
        lcr = 8'h03;
        pop_ticks.delete();
        push(8'h5A);
        push(8'hC3);
        push(8'h0F);
        wait_done();
        check("b2b_pops", pop_ticks.size(), 3);
        if (pop_ticks.size() == 3) begin
            check("b2b_gap1", pop_ticks[1] - pop_ticks[0], 161);
            check("b2b_gap2", pop_ticks[2] - pop_ticks[1], 161);
        end
        check("b2b_busy_low", tx_busy, 0);

        // Randomised frames; lcr is scrambled mid-frame and must not affect the frame in flight.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            lcr = 8'($urandom) & 8'hBF;
            push(8'($urandom));
            wait_state(TX_START);
            @(posedge clk);
            #1;
            lcr = 8'($urandom) & 8'hBF;
            wait_done();
        end

        // Break: live override, FSM keeps running.
        @(posedge clk);
        #1;
        lcr = 8'h03;
        push(8'hFF);
        wait_state(TX_DATA);
        drop_frame = 1'b1;
        @(posedge clk);
        #1;
        lcr = 8'h43;
        @(posedge clk);
        #1;
        check("break_stx", stx_pad_o, 0);
        check("break_state", tstate, 2);
        lcr = 8'h03;
        @(posedge clk);
        #1;
        check("break_release_stx", stx_pad_o, 1);
        lcr = 8'h43;
        wait_state(TX_STOP);
        check("break_stop_stx", stx_pad_o, 0);
        wait_done();
        check("break_frame_ends", tx_busy, 0);
        @(posedge clk);
        #1;
        lcr = 8'h03;

        // tx_reset during PARITY with another byte waiting.
        @(posedge clk);
        #1;
        lcr = 8'h1B;
        push(8'h5A);
        wait_state(TX_PARITY);
        drop_frame = 1'b1;
        @(posedge clk);
        #1;
        tx_reset = 1'b1;
        push(8'hC3);
        @(negedge clk);
        check("txrst_pop", tf_pop, 0);
        @(posedge clk);
        #1;
        check("txrst_state", tstate, 0);
        check("txrst_stx", stx_pad_o, 1);
        repeat (8) begin
            @(negedge clk);
            check("txrst_hold_pop", tf_pop, 0);
        end
        @(posedge clk);
        #1;
        tx_reset = 1'b0;
        wait_done();

        // wb_rst_i during STOP.
        @(posedge clk);
        #1;
        lcr = 8'h07;
        push(8'h96);
        wait_state(TX_STOP);
        drop_frame = 1'b1;
        #1;
        wb_rst_i = 1'b1;
        #1;
        check("rst_state", tstate, 0);
        check("rst_stx", stx_pad_o, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_pop", tf_pop, 0);
        repeat (3) @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        push(8'h96);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_uart_transmitter_wb.md
# peripheral_uart_transmitter_wb

UART serial transmitter for the Wishbone UART peripheral. Pops bytes from the transmit FIFO owned by the parent. Serialises each byte onto `stx_pad_o` as a 16550-style frame: start bit, 5–8 data bits LSB first, optional parity, 1/1.5/2 stop bits. Bit timing comes from the shared x16 baud `enable` tick, so one bit time is 16 enable ticks.

## Interface
Parameters:
- `FIFO_WIDTH`, 8, width of a FIFO entry.
- `FIFO_COUNTER_W`, 5, width of the FIFO occupancy count.

Ports:
- `clk`  in  1  system clock.
- `wb_rst_i`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  baud x16 tick; one-`clk` pulse.
- `lcr`  in  8  line control register:
  - [1:0] word length (0→5, 1→6, 2→7, 3→8 bits).
  - [2] extra stop bit.
  - [3] parity enable.
  - [4] even parity.
  - [5] stick parity.
  - [6] break.
- `tx_reset`  in  1  synchronous frame abort; same cycle as the parent's FIFO reset.
- `tf_data`  in  `FIFO_WIDTH`  FIFO head entry; combinationally valid whenever `tf_count`≠0.
- `tf_count`  in  `FIFO_COUNTER_W`  FIFO occupancy.
- `tf_pop`  out  1  one-`clk` pop strobe to the FIFO.
- `stx_pad_o`  out  1  serial output, registered.
- `tstate`  out  3  current state code.
- `tx_busy`  out  1  frame in progress (`tstate`≠IDLE).

## Operation
- States and codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Internal registers:
  - 5-bit tick counter `tcnt`.
  - 3-bit `bits_left`.
  - 8-bit shift register.
  - latched word length, parity bit, stop length.
- IDLE, `stx`=1: on a cycle with `enable`=1 and `tf_count`≠0:
  - Assert `tf_pop` that cycle.
  - Shift reg ← `tf_data` masked to word length.
  - Latch `lcr[5:0]`-derived config.
  - `tcnt`←15, → START.
- Config is frame-atomic: `lcr` changes mid-frame take effect at the next pop. Exception: break, `lcr[6]`, is live.
- START, `stx`=0: on `enable`, `tcnt`--. Leaving a state: on `enable` with `tcnt`=0, go to the next state with `tcnt`←15 (STOP reloads per below).
- START → DATA with `bits_left`=wordlen−1.
- DATA, `stx`=shift[0]: at end of bit, shift right and `bits_left`--. After the last bit → PARITY if the latched parity enable is set, else STOP.
- PARITY, `stx`=parity bit, 16 ticks. Parity bit rules:
  - stick=0: even → XOR of data bits; odd → XNOR.
  - stick=1: bit = ~even.
- STOP, `stx`=1: `tcnt` loaded at entry by stop length:
  - 15 when `lcr[2]`=0 (1 bit).
  - 23 when `lcr[2]`=1 and 5-bit word (1.5 bits).
  - 31 otherwise (2 bits).
- STOP end → IDLE.
- Break: `lcr[6]`=1 forces `stx_pad_o`=0 in every state. The FSM keeps running, so break never blocks pops.
- `tx_reset`=1 (sync, priority over all but `wb_rst_i`):
  - State → IDLE, `stx`=1, counters 0.
  - `tf_pop`=0 that cycle.
- `enable`=0 freezes the FSM and counters; `stx` holds.
- Empty FIFO: remain in IDLE, `tf_pop` never asserted.

## Timing
- Reset values: `stx_pad_o`=1, `tf_pop`=0, `tstate`=0, `tx_busy`=0, all internal registers 0.
- `tf_pop` is combinational from state/`enable`/`tf_count`. It is high exactly one `clk` per frame.
- `stx_pad_o` and `tstate` update at the `clk` edge that samples the transition-causing `enable`.
- Frame length in enable ticks = 16·(1 + wordlen + parity) + stop ticks (16/24/32).
- One IDLE tick separates back-to-back frames, so frame period = frame length + 1 tick.
- `wb_rst_i` asserted mid-frame: outputs return to reset values immediately. No partial frame is resumed.

## Structure
- `peripheral_wb_pkg` holds:
  - the state enum (3-bit codes above);
  - `lcr` bit-index constants;
  - stop-tick constants 15/23/31.
- No sub-module. The FIFO stays in the parent and connects through `tf_data`/`tf_count`/`tf_pop`.

## Test plan
- 8N1, `lcr`=0x03, push 0xA5, `enable` every 4 clk:
  - exactly one `tf_pop`;
  - `stx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks;
  - 161 ticks until `tx_busy` falls.
- 7E1, `lcr`=0x1A, data 0x41 (0x41 masked to 7 bits, two ones): parity bit 0. 7O1, `lcr`=0x0A: parity bit 1. Stick even, `lcr`=0x3A: parity 0.
- 5-bit, 1.5 stop, `lcr`=0x04: STOP lasts 24 ticks. 8-bit with `lcr`=0x07: STOP lasts 32 ticks.
- Three bytes queued (`tf_count`=3):
  - three pops spaced exactly 161 ticks apart;
  - no stall when `tf_count` drops to 0 after the last pop;
  - `tx_busy` falls after the third frame.
- `lcr[6]` set mid-DATA: `stx`=0 immediately while `tstate` keeps advancing. Cleared: `stx` resumes the current bit value.
- `tx_reset` pulse in PARITY, and `wb_rst_i` asserted in STOP: next `clk` (or immediately, for `wb_rst_i`) `tstate`=0, `stx`=1, no pop. A new byte afterwards transmits a clean full frame.
